// File: rtl/regfile_read_2r1w.sv
// regfile_read_2r1w: DEPTH x WIDTH register file, one write port, two registered read ports.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 at posedge clears file and read outputs)
//   wr_en      write strobe; wr_addr / wr_data give index and value
//   rd_req     read request; samples rd_addr_a / rd_addr_b this cycle
//   rd_data_a  registered port A data (1-cycle latency, held when rd_req==0)
//   rd_data_b  registered port B data (1-cycle latency, held when rd_req==0)
//   rd_valid   rd_data_a/b carry the result of the previous cycle's request
//
// ZERO_REG always reads 0 and ignores writes; indices >= DEPTH behave the same way.
//
// Build option:
//   REGFILE_BYPASS_EN  defined   -> a read of the address being written this cycle returns wr_data
//                      undefined -> that read returns the pre-write contents
module regfile_read_2r1w #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid
);

  // Storage and read-side flops
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_valid_q, rd_valid_d;

  logic             wr_ok;
  logic [WIDTH-1:0] rd_word_a;
  logic [WIDTH-1:0] rd_word_b;

  // True for an index that maps onto a real, writable entry
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (addr != ADDR_W'(ZERO_REG)) && (32'(addr) < DEPTH);
  endfunction

  // Write qualification and next-state of the storage array
  always_comb begin
    wr_ok = wr_en && addr_ok(wr_addr);
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read word selection for both ports (zero reg / out of range read 0)
  always_comb begin
    rd_word_a = '0;
    rd_word_b = '0;
    if (addr_ok(rd_addr_a)) begin
      rd_word_a = mem_q[rd_addr_a];
    end
    if (addr_ok(rd_addr_b)) begin
      rd_word_b = mem_q[rd_addr_b];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes the zero reg and out-of-range indices
    if (wr_ok && (wr_addr == rd_addr_a)) begin
      rd_word_a = wr_data;
    end
    if (wr_ok && (wr_addr == rd_addr_b)) begin
      rd_word_b = wr_data;
    end
`endif
  end

  // Read output next-state: capture on request, otherwise hold data and drop valid
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_valid_d  = rd_req;
    if (rd_req) begin
      rd_data_a_d = rd_word_a;
      rd_data_b_d = rd_word_b;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;

endmodule
